// File: rtl/cpu_pkg.sv
// Shared types and encodings for the RISC control unit: FSM states,
// opcode/op values, writeback selects and ALU operations.
package cpu_pkg;

  typedef enum logic [2:0] {
    S_WAIT,
    S_DECODE,
    S_WRITE_IMM,
    S_GET_A,
    S_GET_B,
    S_EXEC,
    S_WRITE_REG
  } state_t;

  localparam logic [2:0] OP_MOV = 3'b110;
  localparam logic [2:0] OP_ALU = 3'b101;

  localparam logic [1:0] MOV_IMM = 2'b10;
  localparam logic [1:0] MOV_REG = 2'b00;

  localparam logic [1:0] VSEL_MDATA = 2'd0;
  localparam logic [1:0] VSEL_IMM8  = 2'd1;
  localparam logic [1:0] VSEL_PC    = 2'd2;
  localparam logic [1:0] VSEL_C     = 2'd3;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_MVN = 2'b11;

  // Every ALU op is legal; only two of the four MOV variants exist.
  function automatic logic is_defined(input logic [2:0] opcode, input logic [1:0] op);
    return (opcode == OP_ALU) ||
           ((opcode == OP_MOV) && ((op == MOV_IMM) || (op == MOV_REG)));
  endfunction

endpackage

// File: rtl/cpu_controller_if.sv
// Instruction-source handshake plus every datapath control line driven
// by the controller. master = controller side, slave = source/datapath side.
interface cpu_controller_if;
  logic        s;
  logic        load;
  logic [15:0] in;
  logic        w;
  logic [2:0]  readnum;
  logic [2:0]  writenum;
  logic [1:0]  vsel;
  logic        loada;
  logic        loadb;
  logic        loadc;
  logic        loads;
  logic        write;
  logic        asel;
  logic        bsel;
  logic [1:0]  shift;
  logic [1:0]  ALUop;
  logic [15:0] sximm8;
  logic [15:0] sximm5;

  modport master (
    input  s, load, in,
    output w, readnum, writenum, vsel, loada, loadb, loadc, loads, write,
           asel, bsel, shift, ALUop, sximm8, sximm5
  );

  modport slave (
    output s, load, in,
    input  w, readnum, writenum, vsel, loada, loadb, loadc, loads, write,
           asel, bsel, shift, ALUop, sximm8, sximm5
  );
endinterface

// File: rtl/cpu_controller_instr_dec.sv
// Combinational field extraction and sign extension from the instruction
// register.
module instr_dec (
  input  logic [15:0] ir,
  output logic [2:0]  opcode,
  output logic [1:0]  op,
  output logic [2:0]  rn,
  output logic [2:0]  rd,
  output logic [1:0]  sh,
  output logic [2:0]  rm,
  output logic [15:0] sximm8,
  output logic [15:0] sximm5
);

  assign opcode = ir[15:13];
  assign op     = ir[12:11];
  assign rn     = ir[10:8];
  assign rd     = ir[7:5];
  assign sh     = ir[4:3];
  assign rm     = ir[2:0];
  assign sximm8 = {{8{ir[7]}}, ir[7:0]};
  assign sximm5 = {{11{ir[4]}}, ir[4:0]};

endmodule

// File: rtl/cpu_controller.sv
// Control unit: instruction register, decode, and a Moore FSM that drives
// every datapath control input.
module cpu_controller
  import cpu_pkg::*;
(
  input logic       clk,
  input logic       reset,
  cpu_controller_if.master bus
);

  state_t      state_reg;
  state_t      state_next;
  logic [15:0] ir_reg;

  logic [2:0]  opcode;
  logic [1:0]  op;
  logic [2:0]  rn;
  logic [2:0]  rd;
  logic [1:0]  sh;
  logic [2:0]  rm;
  logic [15:0] sximm8;
  logic [15:0] sximm5;

  logic [2:0]  readnum_next;
  logic [2:0]  writenum_next;
  logic [1:0]  vsel_next;
  logic        loada_next;
  logic        loadb_next;
  logic        loadc_next;
  logic        loads_next;
  logic        write_next;
  logic        asel_next;
  logic        bsel_next;
  logic [1:0]  shift_next;
  logic [1:0]  aluop_next;

  instr_dec u_dec (
    .ir     (ir_reg),
    .opcode (opcode),
    .op     (op),
    .rn     (rn),
    .rd     (rd),
    .sh     (sh),
    .rm     (rm),
    .sximm8 (sximm8),
    .sximm5 (sximm5)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= S_WAIT;
    end else begin
      state_reg <= state_next;
    end
  end

  // IR only changes between instructions, so it is stable while sequencing.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ir_reg <= '0;
    end else if ((state_reg == S_WAIT) && bus.load) begin
      ir_reg <= bus.in;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_WAIT:      if (bus.s) state_next = S_DECODE;
      S_DECODE: begin
        if (!is_defined(opcode, op))                    state_next = S_WAIT;
        else if ((opcode == OP_MOV) && (op == MOV_IMM)) state_next = S_WRITE_IMM;
        else if ((opcode == OP_MOV) || (op == ALU_MVN)) state_next = S_GET_B;
        else                                            state_next = S_GET_A;
      end
      S_GET_A:     state_next = S_GET_B;
      S_GET_B:     state_next = S_EXEC;
      S_EXEC:      state_next = ((opcode == OP_ALU) && (op == ALU_SUB)) ? S_WAIT : S_WRITE_REG;
      S_WRITE_IMM: state_next = S_WAIT;
      S_WRITE_REG: state_next = S_WAIT;
      default:     state_next = S_WAIT;
    endcase
  end

  // Register numbers idle at Rn so the register file never sees X.
  always_comb begin
    readnum_next  = rn;
    writenum_next = rn;
    vsel_next     = VSEL_MDATA;
    loada_next    = 1'b0;
    loadb_next    = 1'b0;
    loadc_next    = 1'b0;
    loads_next    = 1'b0;
    write_next    = 1'b0;
    asel_next     = 1'b0;
    bsel_next     = 1'b0;
    shift_next    = 2'b00;
    aluop_next    = ALU_ADD;
    case (state_reg)
      S_WRITE_IMM: begin
        vsel_next  = VSEL_IMM8;
        write_next = 1'b1;
      end
      S_GET_A: loada_next = 1'b1;
      S_GET_B: begin
        readnum_next = rm;
        loadb_next   = 1'b1;
      end
      S_EXEC: begin
        shift_next = sh;
        loadc_next = 1'b1;
        if (opcode == OP_MOV) begin
          asel_next = 1'b1;
        end else begin
          aluop_next = op;
          if (op == ALU_SUB) begin
            loadc_next = 1'b0;
            loads_next = 1'b1;
          end
        end
      end
      S_WRITE_REG: begin
        writenum_next = rd;
        vsel_next     = VSEL_C;
        write_next    = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.w        = (state_reg == S_WAIT);
  assign bus.readnum  = readnum_next;
  assign bus.writenum = writenum_next;
  assign bus.vsel     = vsel_next;
  assign bus.loada    = loada_next;
  assign bus.loadb    = loadb_next;
  assign bus.loadc    = loadc_next;
  assign bus.loads    = loads_next;
  assign bus.write    = write_next;
  assign bus.asel     = asel_next;
  assign bus.bsel     = bsel_next;
  assign bus.shift    = shift_next;
  assign bus.ALUop    = aluop_next;
  assign bus.sximm8   = sximm8;
  assign bus.sximm5   = sximm5;

endmodule

// File: tb/tb_cpu_controller.sv
// Self-checking bench for cpu_controller: directed and randomized
// instructions compared cycle by cycle against an instruction-level model.
module tb_cpu_controller;

  logic clk = 1'b0;
  logic reset;
  cpu_controller_if bus();

  cpu_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        w;
    logic [2:0]  readnum;
    logic [2:0]  writenum;
    logic [1:0]  vsel;
    logic        loada;
    logic        loadb;
    logic        loadc;
    logic        loads;
    logic        write;
    logic        asel;
    logic        bsel;
    logic [1:0]  shift;
    logic [1:0]  aluop;
    logic [15:0] sximm8;
    logic [15:0] sximm5;
  } ctl_t;

  typedef enum {K_MOVI, K_MOVR, K_ADD, K_CMP, K_AND, K_MVN, K_UNDEF} kind_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] last_ir  = 16'h0000;
  ctl_t        exp_q[$];

  function automatic ctl_t sample();
    ctl_t c;
    c.w = bus.w;  c.readnum = bus.readnum;  c.writenum = bus.writenum;
    c.vsel = bus.vsel;  c.loada = bus.loada;  c.loadb = bus.loadb;
    c.loadc = bus.loadc;  c.loads = bus.loads;  c.write = bus.write;
    c.asel = bus.asel;  c.bsel = bus.bsel;  c.shift = bus.shift;
    c.aluop = bus.ALUop;  c.sximm8 = bus.sximm8;  c.sximm5 = bus.sximm5;
    return c;
  endfunction

  function automatic kind_t classify(input logic [15:0] ir);
    if (ir[15:13] == 3'b110 && ir[12:11] == 2'b10) return K_MOVI;
    if (ir[15:13] == 3'b110 && ir[12:11] == 2'b00) return K_MOVR;
    if (ir[15:13] == 3'b101) begin
      case (ir[12:11])
        2'b00:   return K_ADD;
        2'b01:   return K_CMP;
        2'b10:   return K_AND;
        default: return K_MVN;
      endcase
    end
    return K_UNDEF;
  endfunction

  function automatic int latency(input kind_t k);
    case (k)
      K_MOVI:        return 3;
      K_MOVR, K_MVN: return 5;
      K_ADD, K_AND:  return 6;
      K_CMP:         return 5;
      default:       return 2;
    endcase
  endfunction

  // Quiet outputs for a given IR: nothing enabled, register numbers at Rn.
  function automatic ctl_t quiet(input logic [15:0] ir, input logic w);
    ctl_t c = '0;
    c.w        = w;
    c.readnum  = ir[10:8];
    c.writenum = ir[10:8];
    c.sximm8   = 16'($signed(ir[7:0]));
    c.sximm5   = 16'($signed(ir[4:0]));
    return c;
  endfunction

  task automatic build(input logic [15:0] ir);
    kind_t k = classify(ir);
    ctl_t  c;
    exp_q.delete();
    exp_q.push_back(quiet(ir, 1'b0));
    if (k == K_MOVI) begin
      c = quiet(ir, 1'b0); c.vsel = 2'd1; c.write = 1'b1; exp_q.push_back(c);
    end else if (k != K_UNDEF) begin
      if (k == K_ADD || k == K_CMP || k == K_AND) begin
        c = quiet(ir, 1'b0); c.loada = 1'b1; exp_q.push_back(c);
      end
      c = quiet(ir, 1'b0); c.readnum = ir[2:0]; c.loadb = 1'b1; exp_q.push_back(c);
      c = quiet(ir, 1'b0); c.shift = ir[4:3];
      if (k == K_MOVR)     begin c.asel = 1'b1; c.aluop = 2'b00; c.loadc = 1'b1; end
      else if (k == K_CMP) begin c.aluop = 2'b01; c.loads = 1'b1; end
      else                 begin c.aluop = ir[12:11]; c.loadc = 1'b1; end
      exp_q.push_back(c);
      if (k != K_CMP) begin
        c = quiet(ir, 1'b0); c.writenum = ir[7:5]; c.vsel = 2'd3; c.write = 1'b1;
        exp_q.push_back(c);
      end
    end
    exp_q.push_back(quiet(ir, 1'b1));
  endtask

  task automatic wait_idle();
    int guard = 0;
    while (bus.w !== 1'b1 && guard < 20) begin
      @(posedge clk); #1; guard++;
    end
    if (bus.w !== 1'b1) begin
      n_checks++; n_fail++;
      $display("FAIL wait_idle: w=%b required 1 within 20 cycles", bus.w);
    end
  endtask

  // noisy: toggle load/s/in while busy; noise_word 0 means random words.
  task automatic run_instr(input string name, input logic [15:0] ir, input bit do_load,
                           input bit noisy, input logic [15:0] noise_word);
    ctl_t        got;
    int          lat = 0;
    logic [15:0] eff;
    @(negedge clk);
    bus.in = do_load ? ir : 16'($urandom); bus.load = do_load; bus.s = 1'b1;
    eff = do_load ? ir : last_ir;
    @(posedge clk); #1;
    bus.load = 1'b0; bus.s = 1'b0;
    last_ir = eff;
    build(eff);
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      got = sample();
      n_checks++;
      if (got !== exp_q[i]) begin
        n_fail++;
        $display("FAIL %s ir=%h cyc %0d: got %h required %h", name, eff, i + 1, got, exp_q[i]);
      end
      if (got.w === 1'b1 && lat == 0) lat = i + 1;
      if (noisy && i < exp_q.size() - 1) begin
        bus.load = 1'b1; bus.s = 1'($urandom);
        bus.in = (noise_word != 16'h0) ? noise_word : 16'($urandom);
      end else begin
        bus.load = 1'b0; bus.s = 1'b0;
      end
    end
    n_checks++;
    if (lat != latency(classify(eff))) begin
      n_fail++;
      $display("FAIL %s_latency ir=%h: got %0d required %0d", name, eff, lat, latency(classify(eff)));
    end
    $display("txn %s ir=%h latency=%0d", name, eff, lat);
    wait_idle();
  endtask

  task automatic test_reset();
    ctl_t got;
    reset = 1'b1; bus.s = 1'b0; bus.load = 1'b0; bus.in = 16'hFFFF;
    repeat (2) @(posedge clk);
    #1 got = sample();
    n_checks++;
    if (got !== quiet(16'h0, 1'b1)) begin
      n_fail++; $display("FAIL reset_state: got %h required %h", got, quiet(16'h0, 1'b1));
    end
    @(negedge clk); reset = 1'b0;
    last_ir = 16'h0;
    $display("txn reset");
  endtask

  task automatic test_async_reset();
    ctl_t got;
    @(negedge clk);
    bus.in = 16'hA140; bus.load = 1'b1; bus.s = 1'b1;
    @(posedge clk); #1 bus.load = 1'b0; bus.s = 1'b0;
    @(posedge clk); #1;
    #2 reset = 1'b1;
    #1 got = sample();
    n_checks++;
    if (got !== quiet(16'h0, 1'b1)) begin
      n_fail++; $display("FAIL async_reset: got %h required %h", got, quiet(16'h0, 1'b1));
    end
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1 got = sample();
    n_checks++;
    if (got !== quiet(16'h0, 1'b1)) begin
      n_fail++; $display("FAIL after_reset_idle: got %h required %h", got, quiet(16'h0, 1'b1));
    end
    last_ir = 16'h0;
    $display("txn async_reset");
  endtask

  task automatic test_load_only();
    ctl_t got;
    @(negedge clk); bus.in = 16'hD0F9; bus.load = 1'b1; bus.s = 1'b0;
    @(posedge clk); #1 bus.load = 1'b0;
    got = sample();
    n_checks++;
    if (got !== quiet(16'hD0F9, 1'b1)) begin
      n_fail++; $display("FAIL load_only: got %h required %h", got, quiet(16'hD0F9, 1'b1));
    end
    last_ir = 16'hD0F9;
    $display("txn load_only ir=d0f9");
  endtask

  task automatic test_directed();
    run_instr("mov_imm", 16'hD007, 1'b1, 1'b0, 16'h0);
    run_instr("mov_imm_neg", 16'hD0F9, 1'b1, 1'b0, 16'h0);
    run_instr("add", 16'hA140, 1'b1, 1'b0, 16'h0);
    run_instr("cmp", 16'hA900, 1'b1, 1'b0, 16'h0);
    run_instr("mvn", 16'hB869, 1'b1, 1'b0, 16'h0);
    run_instr("and", 16'hB0B3, 1'b1, 1'b0, 16'h0);
    run_instr("mov_reg", 16'hC0F5, 1'b1, 1'b0, 16'h0);
    run_instr("undef", 16'h0000, 1'b1, 1'b0, 16'h0);
    run_instr("undef_mov", 16'hD8FF, 1'b1, 1'b0, 16'h0);
  endtask

  task automatic test_busy_load();
    run_instr("busy_load", 16'hA140, 1'b1, 1'b1, 16'hD0FF);
    run_instr("start_no_load", 16'h0, 1'b0, 1'b0, 16'h0);
  endtask

  task automatic test_random();
    logic [15:0] ir;
    logic [4:0]  heads[6] = '{5'b11010, 5'b11000, 5'b10100, 5'b10101, 5'b10110, 5'b10111};
    for (int n = 0; n < 40; n++) begin
      ir = 16'($urandom);
      if ($urandom_range(0, 2) != 0) ir[15:11] = heads[$urandom_range(0, 5)];
      run_instr("random", ir, 1'b1, 1'($urandom), 16'h0);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_load_only();
    test_busy_load();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
